// File: rtl/arrhythmia_dtree_top_if.sv
// ---------------------------------------------------------------------------
// arrhythmia_dtree_top_if
//   Bundles the classifier's feature-vector input side and its class-label
//   result side into one interface.
//
//   Signals:
//     in_valid   1  feature vector on X* is valid this cycle
//     X0..X276   8  unsigned quantised ECG features (45 of them, node order)
//     out        5  class label 0..31
//     out_valid  1  out holds a fresh result this cycle
//
//   Modports:
//     master  - producer of feature vectors / consumer of labels (bench side)
//     slave   - the classifier itself
// ---------------------------------------------------------------------------
interface arrhythmia_dtree_top_if;
    logic       in_valid;
    logic [7:0] X0,   X2,   X5,   X9,   X10,  X12,  X13,  X50,  X55,  X74,
                X91,  X124, X139, X147, X164, X170, X171, X175, X180, X184,
                X186, X190, X195, X199, X205, X209, X216, X221, X222, X235,
                X236, X240, X246, X251, X255, X256, X257, X258, X261, X264,
                X265, X271, X274, X275, X276;
    logic [4:0] out;
    logic       out_valid;

    modport master (
        output in_valid,
        output X0,   X2,   X5,   X9,   X10,  X12,  X13,  X50,  X55,  X74,
               X91,  X124, X139, X147, X164, X170, X171, X175, X180, X184,
               X186, X190, X195, X199, X205, X209, X216, X221, X222, X235,
               X236, X240, X246, X251, X255, X256, X257, X258, X261, X264,
               X265, X271, X274, X275, X276,
        input  out,
        input  out_valid
    );

    modport slave (
        input  in_valid,
        input  X0,   X2,   X5,   X9,   X10,  X12,  X13,  X50,  X55,  X74,
               X91,  X124, X139, X147, X164, X170, X171, X175, X180, X184,
               X186, X190, X195, X199, X205, X209, X216, X221, X222, X235,
               X236, X240, X246, X251, X255, X256, X257, X258, X261, X264,
               X265, X271, X274, X275, X276,
        output out,
        output out_valid
    );
endinterface

// File: rtl/arrhythmia_dtree_top.sv
// ---------------------------------------------------------------------------
// arrhythmia_dtree_top
//   Decision-list classifier over 45 quantised arrhythmia ECG features.
//   Nodes are examined in port order; node k fires when its feature is
//   strictly greater (unsigned) than its 8-bit threshold, and the lowest
//   firing node supplies the class label. If nothing fires the label is
//   DEFAULT_CLASS. The label is registered, so one vector per cycle is
//   accepted with no back-pressure.
//
//   Ports:
//     clk   rising-edge clock
//     rst   asynchronous active-high reset (clears out / out_valid)
//     bus   arrhythmia_dtree_top_if.slave: in_valid, X*, out, out_valid
//
//   Configuration macro:
//     DTREE_INPUT_REG_EN  when defined, X* and in_valid are registered
//                         before the decision logic (latency 2 cycles);
//                         otherwise inputs feed it directly (latency 1).
// ---------------------------------------------------------------------------
module arrhythmia_dtree_top #(
    parameter logic [359:0] THRESH        = {45{8'd127}},
    // Node k label is (k % 16) + 1; node 44 sits in the MSBs.
    parameter logic [224:0] LABEL         = {
        5'd13, 5'd12, 5'd11, 5'd10, 5'd9,  5'd8,  5'd7,  5'd6,  5'd5,
        5'd4,  5'd3,  5'd2,  5'd1,
        5'd16, 5'd15, 5'd14, 5'd13, 5'd12, 5'd11, 5'd10, 5'd9,
        5'd8,  5'd7,  5'd6,  5'd5,  5'd4,  5'd3,  5'd2,  5'd1,
        5'd16, 5'd15, 5'd14, 5'd13, 5'd12, 5'd11, 5'd10, 5'd9,
        5'd8,  5'd7,  5'd6,  5'd5,  5'd4,  5'd3,  5'd2,  5'd1
    },
    parameter logic [4:0]   DEFAULT_CLASS = 5'd1
) (
    input  logic                 clk,
    input  logic                 rst,
    arrhythmia_dtree_top_if.slave bus
);

    localparam int NODES = 45;

    // Features gathered into node order.
    logic [7:0] feat [NODES];

    assign feat[0]  = bus.X0;
    assign feat[1]  = bus.X2;
    assign feat[2]  = bus.X5;
    assign feat[3]  = bus.X9;
    assign feat[4]  = bus.X10;
    assign feat[5]  = bus.X12;
    assign feat[6]  = bus.X13;
    assign feat[7]  = bus.X50;
    assign feat[8]  = bus.X55;
    assign feat[9]  = bus.X74;
    assign feat[10] = bus.X91;
    assign feat[11] = bus.X124;
    assign feat[12] = bus.X139;
    assign feat[13] = bus.X147;
    assign feat[14] = bus.X164;
    assign feat[15] = bus.X170;
    assign feat[16] = bus.X171;
    assign feat[17] = bus.X175;
    assign feat[18] = bus.X180;
    assign feat[19] = bus.X184;
    assign feat[20] = bus.X186;
    assign feat[21] = bus.X190;
    assign feat[22] = bus.X195;
    assign feat[23] = bus.X199;
    assign feat[24] = bus.X205;
    assign feat[25] = bus.X209;
    assign feat[26] = bus.X216;
    assign feat[27] = bus.X221;
    assign feat[28] = bus.X222;
    assign feat[29] = bus.X235;
    assign feat[30] = bus.X236;
    assign feat[31] = bus.X240;
    assign feat[32] = bus.X246;
    assign feat[33] = bus.X251;
    assign feat[34] = bus.X255;
    assign feat[35] = bus.X256;
    assign feat[36] = bus.X257;
    assign feat[37] = bus.X258;
    assign feat[38] = bus.X261;
    assign feat[39] = bus.X264;
    assign feat[40] = bus.X265;
    assign feat[41] = bus.X271;
    assign feat[42] = bus.X274;
    assign feat[43] = bus.X275;
    assign feat[44] = bus.X276;

    // Operands seen by the decision logic.
    logic [7:0] dec_feat [NODES];
    logic       dec_vld;

`ifdef DTREE_INPUT_REG_EN
    // ---- stage p0: input capture ----
    logic [7:0] feat_p0 [NODES];
    logic       vld_p0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p0 <= 1'b0;
            for (int k = 0; k < NODES; k++) begin
                feat_p0[k] <= 8'd0;
            end
        end else begin
            vld_p0 <= bus.in_valid;
            for (int k = 0; k < NODES; k++) begin
                feat_p0[k] <= feat[k];
            end
        end
    end

    always_comb begin
        dec_vld = vld_p0;
        for (int k = 0; k < NODES; k++) begin
            dec_feat[k] = feat_p0[k];
        end
    end
`else
    always_comb begin
        dec_vld = bus.in_valid;
        for (int k = 0; k < NODES; k++) begin
            dec_feat[k] = feat[k];
        end
    end
`endif

    // Walking from the last node toward node 0 lets the lowest firing node
    // overwrite every higher one, giving first-match priority.
    logic [4:0] cls;

    always_comb begin
        cls = DEFAULT_CLASS;
        for (int k = NODES - 1; k >= 0; k--) begin
            if (dec_feat[k] > THRESH[8*k +: 8]) begin
                cls = LABEL[5*k +: 5];
            end
        end
    end

    // ---- stage p1: registered result ----
    logic [4:0] out_p1;
    logic       vld_p1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_p1 <= 5'd0;
            vld_p1 <= 1'b0;
        end else begin
            vld_p1 <= dec_vld;
            if (dec_vld) begin
                out_p1 <= cls;
            end
        end
    end

    assign bus.out       = out_p1;
    assign bus.out_valid = vld_p1;

endmodule

// File: tb/tb_arrhythmia_dtree_top.sv
// ---------------------------------------------------------------------------
// tb_arrhythmia_dtree_top
//   Directed bench for arrhythmia_dtree_top. A behavioural model derives the
//   expected label from the decision-list rules (threshold 127, label
//   (k%16)+1, default 1) and is compared to the DUT every cycle; literal
//   expectations pin both the DUT and the model at key points.
// ---------------------------------------------------------------------------
module tb_arrhythmia_dtree_top;

`ifdef DTREE_INPUT_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic vin = 1'b0;
    logic [7:0] fv [45];

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    arrhythmia_dtree_top_if bus ();

    arrhythmia_dtree_top dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    assign bus.in_valid = vin;
    assign bus.X0   = fv[0];   assign bus.X2   = fv[1];   assign bus.X5   = fv[2];
    assign bus.X9   = fv[3];   assign bus.X10  = fv[4];   assign bus.X12  = fv[5];
    assign bus.X13  = fv[6];   assign bus.X50  = fv[7];   assign bus.X55  = fv[8];
    assign bus.X74  = fv[9];   assign bus.X91  = fv[10];  assign bus.X124 = fv[11];
    assign bus.X139 = fv[12];  assign bus.X147 = fv[13];  assign bus.X164 = fv[14];
    assign bus.X170 = fv[15];  assign bus.X171 = fv[16];  assign bus.X175 = fv[17];
    assign bus.X180 = fv[18];  assign bus.X184 = fv[19];  assign bus.X186 = fv[20];
    assign bus.X190 = fv[21];  assign bus.X195 = fv[22];  assign bus.X199 = fv[23];
    assign bus.X205 = fv[24];  assign bus.X209 = fv[25];  assign bus.X216 = fv[26];
    assign bus.X221 = fv[27];  assign bus.X222 = fv[28];  assign bus.X235 = fv[29];
    assign bus.X236 = fv[30];  assign bus.X240 = fv[31];  assign bus.X246 = fv[32];
    assign bus.X251 = fv[33];  assign bus.X255 = fv[34];  assign bus.X256 = fv[35];
    assign bus.X257 = fv[36];  assign bus.X258 = fv[37];  assign bus.X261 = fv[38];
    assign bus.X264 = fv[39];  assign bus.X265 = fv[40];  assign bus.X271 = fv[41];
    assign bus.X274 = fv[42];  assign bus.X275 = fv[43];  assign bus.X276 = fv[44];

    // First node (in list order) whose feature exceeds 127 decides.
    function automatic logic [4:0] model_class(input logic [7:0] f [45]);
        for (int k = 0; k < 45; k++) begin
            if (int'(f[k]) > 127) return 5'((k % 16) + 1);
        end
        return 5'd1;
    endfunction

    logic [4:0] mo = 5'd0;
    logic       mv = 1'b0;
`ifdef DTREE_INPUT_REG_EN
    logic [4:0] pc = 5'd0;
    logic       pv = 1'b0;
`endif

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mo <= 5'd0;
            mv <= 1'b0;
`ifdef DTREE_INPUT_REG_EN
            pc <= 5'd0;
            pv <= 1'b0;
`endif
        end else begin
`ifdef DTREE_INPUT_REG_EN
            pv <= vin;
            pc <= model_class(fv);
            mv <= pv;
            if (pv) mo <= pc;
`else
            mv <= vin;
            if (vin) mo <= model_class(fv);
`endif
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (!rst) begin
            n_vec++;
            if (bus.out_valid !== mv || bus.out !== mo) begin
                n_miss++;
                $display("FAIL cycle t=%0t: out=%0d out_valid=%0b, model requires out=%0d out_valid=%0b",
                         $time, bus.out, bus.out_valid, mo, mv);
            end
        end
    end

    task automatic check(input string name, input logic [4:0] eo, input logic ev);
        n_vec++;
        if (bus.out !== eo || bus.out_valid !== ev || mo !== eo || mv !== ev) begin
            n_miss++;
            $display("FAIL %s: dut out=%0d vld=%0b model out=%0d vld=%0b, required out=%0d vld=%0b",
                     name, bus.out, bus.out_valid, mo, mv, eo, ev);
        end
    endtask

    task automatic clear_fv();
        for (int i = 0; i < 45; i++) fv[i] = 8'd0;
    endtask

    // Present the current fv for one cycle, then wait until its label is out.
    task automatic run_one(input string name, input logic [4:0] eo);
        vin = 1'b1;
        @(negedge clk);
        vin = 1'b0;
        repeat (LAT - 1) @(negedge clk);
        check(name, eo, 1'b1);
    endtask

    initial begin
        clear_fv();
        #1 rst = 1'b1;
        #2 check("reset_state", 5'd0, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        clear_fv();
        run_one("all_zero_default", 5'd1);

        clear_fv(); fv[1] = 8'd200;
        run_one("x2_node1", 5'd2);

        clear_fv(); fv[44] = 8'd128;
        run_one("x276_node44", 5'd13);

        clear_fv(); fv[3] = 8'd128; fv[7] = 8'd255;
        run_one("x9_x50_priority", 5'd4);

        clear_fv(); fv[2] = 8'd127;
        run_one("x5_equal_no_fire", 5'd1);

        clear_fv(); fv[2] = 8'd128;
        run_one("x5_above_fires", 5'd3);

        clear_fv(); fv[44] = 8'd127; fv[20] = 8'd128;
        run_one("x186_node20", 5'd5);

        for (int i = 0; i < 45; i++) fv[i] = 8'd255;
        run_one("all_max_node0", 5'd1);

        // Back-to-back stream; the per-cycle compare checks each label.
        clear_fv(); fv[1] = 8'd200; vin = 1'b1;
        @(negedge clk);
        clear_fv(); fv[44] = 8'd128;
        @(negedge clk);
        clear_fv(); fv[4] = 8'd200;
        @(negedge clk);
        vin = 1'b0;
        repeat (LAT - 1) @(negedge clk);
        check("stream_last", 5'd5, 1'b1);
        repeat (2) @(negedge clk);
        check("stream_hold", 5'd5, 1'b0);

        // Asynchronous reset between edges with a vector in flight.
        clear_fv(); fv[3] = 8'd128; vin = 1'b1;
        @(posedge clk);
        #2 rst = 1'b1;
        #1 check("rst_async", 5'd0, 1'b0);
        vin = 1'b0;
        @(negedge clk);
        #2 rst = 1'b0;
        clear_fv(); fv[1] = 8'd200;
        vin = 1'b1;
        @(negedge clk);
        vin = 1'b0;
        repeat (LAT - 1) @(negedge clk);
        check("post_rst", 5'd2, 1'b1);

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
